mult_gpio_bridge: RTL and testbench

- Sits between the MicroBlaze MCS GPIO channels and a 128x128 multiplier core.
- Assembles two 128-bit operands from 32-bit GPIO writes.
- Issues a single-cycle start to the core, waits for done with a watchdog, then latches the 256-bit product.
- Returns the product to software 32 bits at a time through a location-indexed read port and a status word.

---
 rtl/mult_bridge_pkg.sv | 25 ++
 rtl/mult_gpio_bridge_edge.sv | 21 ++
 rtl/mult_gpio_bridge.sv | 157 +++++++++++++++
 tb/tb_mult_gpio_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_bridge_pkg.sv
// Shared constants for the MicroBlaze GPIO to 128x128 multiplier bridge:
// FSM encoding, status/control bit positions and the word-index field width.
package mult_bridge_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERROR = 3'd4;

    localparam int STAT_IDLE    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_DONE    = 2;
    localparam int STAT_ERR_WR  = 3;
    localparam int STAT_TIMEOUT = 4;

    localparam int WR_STROBE = 31;
    localparam int START     = 0;
    localparam int CLEAR     = 1;

    localparam int IDX_W = 3;

endpackage

// File: rtl/mult_gpio_bridge_edge.sv
// Rising-edge detector: one history flop, event is current high and previous low.
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/mult_gpio_bridge.sv
// Bridge between MCS GPIO channels and a 128x128 multiplier core: builds operands
// from 32-bit writes, sequences the core with a watchdog and serves the product.
module mult_gpio_bridge
    import mult_bridge_pkg::*;
#(
    parameter int OP_W    = 128,
    parameter int CHUNK_W = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         in_loc,
    input  logic [CHUNK_W-1:0]  in_val,
    input  logic [31:0]         ctrl_reg,
    input  logic [31:0]         out_loc,
    output logic [CHUNK_W-1:0]  out_val,
    output logic [31:0]         state_reg,
    output logic [OP_W-1:0]     op_a,
    output logic [OP_W-1:0]     op_b,
    output logic                core_start,
    input  logic                core_done,
    input  logic [2*OP_W-1:0]   core_product
);

    localparam int WD_W       = $clog2(TIMEOUT + 1);
    localparam int OP_WORDS   = OP_W / CHUNK_W;
    localparam int PROD_WORDS = 2 * OP_WORDS;

    logic                wr_ev;
    logic                start_ev;
    logic                clear_ev;
    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nxt;
    logic [WD_W-1:0]     wd;
    logic                wd_expire;
    logic                err_wr;
    logic                timeout_flag;
    logic [CHUNK_W-1:0]  a_words [OP_WORDS];
    logic [CHUNK_W-1:0]  b_words [OP_WORDS];
    logic [CHUNK_W-1:0]  prod_words [PROD_WORDS];
    logic [IDX_W-2:0]    wr_word;
    logic [IDX_W-1:0]    rd_word;
    logic                unused_bits;

    edge_detect_rise u_wr_edge (
        .clk  (clk),
        .reset(reset),
        .din  (in_loc[WR_STROBE]),
        .rise (wr_ev)
    );

    edge_detect_rise u_start_edge (
        .clk  (clk),
        .reset(reset),
        .din  (ctrl_reg[START]),
        .rise (start_ev)
    );

    edge_detect_rise u_clear_edge (
        .clk  (clk),
        .reset(reset),
        .din  (ctrl_reg[CLEAR]),
        .rise (clear_ev)
    );

    assign wr_word     = in_loc[IDX_W-2:0];
    assign rd_word     = out_loc[IDX_W-1:0];
    assign wd_expire   = (wd == WD_W'(TIMEOUT - 1));
    assign unused_bits = ^{in_loc[30:IDX_W], ctrl_reg[31:2], out_loc[31:IDX_W]};

    for (genvar g = 0; g < OP_WORDS; g++) begin : g_pack
        assign op_a[g*CHUNK_W +: CHUNK_W] = a_words[g];
        assign op_b[g*CHUNK_W +: CHUNK_W] = b_words[g];
    end

    // Clear overrides everything, including a start arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        if (clear_ev) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ev) state_nxt = ST_ISSUE;
                ST_ISSUE: state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (core_done)      state_nxt = ST_DONE;
                    else if (wd_expire) state_nxt = ST_ERROR;
                end
                ST_DONE:  if (start_ev) state_nxt = ST_ISSUE;
                ST_ERROR: state_nxt = ST_ERROR;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            core_start   <= 1'b0;
            wd           <= '0;
            err_wr       <= 1'b0;
            timeout_flag <= 1'b0;
            out_val      <= '0;
            for (int i = 0; i < OP_WORDS; i++) begin
                a_words[i] <= '0;
                b_words[i] <= '0;
            end
            for (int i = 0; i < PROD_WORDS; i++) prod_words[i] <= '0;
        end else begin
            state      <= state_nxt;
            core_start <= (state_nxt == ST_ISSUE);
            if (clear_ev) begin
                wd           <= '0;
                err_wr       <= 1'b0;
                timeout_flag <= 1'b0;
                out_val      <= '0;
                for (int i = 0; i < OP_WORDS; i++) begin
                    a_words[i] <= '0;
                    b_words[i] <= '0;
                end
                for (int i = 0; i < PROD_WORDS; i++) prod_words[i] <= '0;
            end else begin
                out_val <= prod_words[rd_word];
                if (wr_ev) begin
                    if (state == ST_IDLE || state == ST_DONE) begin
                        if (in_loc[IDX_W-1]) b_words[wr_word] <= in_val;
                        else                 a_words[wr_word] <= in_val;
                    end else begin
                        err_wr <= 1'b1;
                    end
                end
                // Watchdog saturates at TIMEOUT so a stuck ERROR never wraps it.
                if (state == ST_ISSUE) begin
                    wd <= '0;
                end else if (state == ST_WAIT && wd != WD_W'(TIMEOUT)) begin
                    wd <= wd + 1'b1;
                end
                if (state == ST_WAIT && core_done) begin
                    for (int i = 0; i < PROD_WORDS; i++) begin
                        prod_words[i] <= core_product[i*CHUNK_W +: CHUNK_W];
                    end
                end
                if (state == ST_WAIT && !core_done && wd_expire) timeout_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        state_reg               = '0;
        state_reg[STAT_IDLE]    = (state == ST_IDLE);
        state_reg[STAT_BUSY]    = (state == ST_ISSUE) || (state == ST_WAIT);
        state_reg[STAT_DONE]    = (state == ST_DONE);
        state_reg[STAT_ERR_WR]  = err_wr;
        state_reg[STAT_TIMEOUT] = timeout_flag;
    end

endmodule

// File: tb/tb_mult_gpio_bridge.sv
// Self-checking bench for mult_gpio_bridge: directed sequence with random operand
// data, checked against a word-level model of operands, product and status.
module tb_mult_gpio_bridge;

    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_loc;
    logic [31:0]  in_val;
    logic [31:0]  ctrl_reg;
    logic [31:0]  out_loc;
    logic [31:0]  out_val;
    logic [31:0]  state_reg;
    logic [127:0] op_a;
    logic [127:0] op_b;
    logic         core_start;
    logic         core_done;
    logic [255:0] core_product;

    int test_count = 0;
    int fail_count = 0;
    int pulses = 0;
    int p0;

    logic [31:0]  m_a [4];
    logic [31:0]  m_b [4];
    logic [255:0] m_prod;
    int           m_phase;
    logic         m_err;
    logic         m_to;

    always #5 clk = ~clk;

    mult_gpio_bridge #(.OP_W(128), .CHUNK_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_loc      (in_loc),
        .in_val      (in_val),
        .ctrl_reg    (ctrl_reg),
        .out_loc     (out_loc),
        .out_val     (out_val),
        .state_reg   (state_reg),
        .op_a        (op_a),
        .op_b        (op_b),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_product(core_product)
    );

    always @(posedge clk) if (core_start === 1'b1) pulses++;

    function automatic logic [127:0] model_a();
        return {m_a[3], m_a[2], m_a[1], m_a[0]};
    endfunction

    function automatic logic [127:0] model_b();
        return {m_b[3], m_b[2], m_b[1], m_b[0]};
    endfunction

    // Phase: 0 idle, 1 busy, 2 done, 3 error.
    function automatic logic [31:0] model_status();
        return {27'b0, m_to, m_err, m_phase == 2, m_phase == 1, m_phase == 0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_prod = '0; m_phase = 0; m_err = 1'b0; m_to = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] loc, input logic [31:0] val,
                                 input logic [31:0] ctrl);
        in_loc = loc; in_val = val; ctrl_reg = ctrl;
        @(negedge clk);
    endtask

    task automatic write_word(input logic [2:0] idx, input logic [31:0] data);
        applyStimulus({1'b1, 28'b0, idx}, data, 32'h0);
        applyStimulus(32'h0, data, 32'h0);
        if (m_phase == 0 || m_phase == 2) begin
            if (idx[2]) m_b[idx[1:0]] = data;
            else        m_a[idx[1:0]] = data;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic write_random_operands();
        for (int i = 0; i < 8; i++) write_word(3'(i), $urandom | 32'h1);
    endtask

    task automatic do_start();
        applyStimulus(32'h0, 32'h0, 32'h1);
        applyStimulus(32'h0, 32'h0, 32'h0);
        if (m_phase == 0 || m_phase == 2) m_phase = 1;
    endtask

    task automatic do_clear();
        applyStimulus(32'h0, 32'h0, 32'h2);
        model_clear();
    endtask

    task automatic complete(input int delay);
        repeat (delay - 1) @(negedge clk);
        m_prod = {128'b0, model_a()} * {128'b0, model_b()};
        core_product = m_prod;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        m_phase = 2;
    endtask

    task automatic read_all(input string tag);
        logic [255:0] sh;
        for (int i = 0; i < 8; i++) begin
            out_loc = 32'(i);
            @(negedge clk);
            sh = m_prod >> (32 * i);
            checkOutput(tag, {224'b0, out_val}, {224'b0, sh[31:0]});
        end
    endtask

    initial begin
        reset = 1'b1; in_loc = '0; in_val = '0; ctrl_reg = '0; out_loc = '0;
        core_done = 1'b0; core_product = '0;
        model_clear();
        repeat (2) @(negedge clk);
        checkOutput("reset_status", state_reg, 32'h1);
        checkOutput("reset_core_start", core_start, 1'b0);
        checkOutput("reset_out_val", out_val, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_status", state_reg, model_status());

        // A = 1, B = 2, single multiply
        write_word(3'd0, 32'h1);
        for (int i = 1; i < 4; i++) write_word(3'(i), 32'h0);
        write_word(3'd4, 32'h2);
        for (int i = 5; i < 8; i++) write_word(3'(i), 32'h0);
        checkOutput("op_a_written", op_a, model_a());
        checkOutput("op_b_written", op_b, model_b());
        p0 = pulses;
        applyStimulus(32'h0, 32'h0, 32'h1);
        checkOutput("start_latency", core_start, 1'b1);
        applyStimulus(32'h0, 32'h0, 32'h0);
        checkOutput("start_one_cycle", core_start, 1'b0);
        checkOutput("start_pulse_count", 256'(pulses - p0), 256'd1);
        m_phase = 1;
        checkOutput("busy_status", state_reg, model_status());
        complete(5);
        checkOutput("done_status", state_reg, 32'h4);
        out_loc = 32'h0;
        @(negedge clk);
        checkOutput("product_word0", out_val, 32'h2);
        read_all("product_1x2");

        // core_done outside WAIT must not overwrite the product
        core_product = {8{$urandom}};
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        read_all("late_done_ignored");

        // Random operands
        write_random_operands();
        checkOutput("op_a_random", op_a, model_a());
        checkOutput("op_b_random", op_b, model_b());
        do_start();
        complete(3 + int'($urandom_range(0, 6)));
        read_all("product_random");

        // Held start level gives one pulse; a fresh edge from DONE gives another
        p0 = pulses;
        m_phase = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 6) begin
                core_product = {128'b0, model_a()} * {128'b0, model_b()};
                core_done = 1'b1;
            end else begin
                core_done = 1'b0;
            end
            applyStimulus(32'h0, 32'h0, 32'h1);
            if (i == 6) m_phase = 2;
        end
        checkOutput("held_start_pulses", 256'(pulses - p0), 256'd1);
        checkOutput("held_start_status", state_reg, model_status());
        applyStimulus(32'h0, 32'h0, 32'h0);
        applyStimulus(32'h0, 32'h0, 32'h1);
        m_phase = 1;
        checkOutput("restart_pulse", core_start, 1'b1);
        checkOutput("restart_done_drops", state_reg, model_status());
        applyStimulus(32'h0, 32'h0, 32'h0);
        checkOutput("restart_pulse_count", 256'(pulses - p0), 256'd2);
        complete(4);
        read_all("product_restart");

        // Write during WAIT is rejected and flagged
        do_start();
        write_word(3'd0, $urandom | 32'h2);
        checkOutput("wait_write_op_a", op_a, model_a());
        checkOutput("wait_write_status", state_reg, model_status());
        checkOutput("err_wr_bit", state_reg[3], 1'b1);
        do_clear();
        checkOutput("clear_status", state_reg, 32'h1);
        checkOutput("clear_op_a", op_a, 128'h0);
        checkOutput("clear_op_b", op_b, 128'h0);
        applyStimulus(32'h0, 32'h0, 32'h0);

        // Watchdog timeout: exactly TIMEOUT cycles in WAIT
        write_word(3'd0, $urandom | 32'h1);
        do_start();
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("timeout_edge_busy", state_reg, model_status());
        @(negedge clk);
        m_phase = 3; m_to = 1'b1;
        checkOutput("timeout_status", state_reg, 32'h10);
        p0 = pulses;
        do_start();
        checkOutput("error_start_ignored", 256'(pulses - p0), 256'd0);
        checkOutput("error_status_held", state_reg, model_status());
        do_clear();
        checkOutput("error_clear_status", state_reg, 32'h1);
        applyStimulus(32'h0, 32'h0, 32'h0);

        // Clear and start together from DONE: clear wins
        write_random_operands();
        do_start();
        complete(5);
        checkOutput("pre_clear_done", state_reg, model_status());
        p0 = pulses;
        applyStimulus(32'h0, 32'h0, 32'h3);
        model_clear();
        checkOutput("clear_start_status", state_reg, 32'h1);
        checkOutput("clear_start_no_pulse", core_start, 1'b0);
        applyStimulus(32'h0, 32'h0, 32'h0);
        checkOutput("clear_start_pulses", 256'(pulses - p0), 256'd0);
        read_all("product_cleared");

        // Asynchronous reset in the middle of WAIT
        write_random_operands();
        do_start();
        complete(3);
        out_loc = 32'h0;
        @(negedge clk);
        checkOutput("pre_reset_out_val", out_val, {224'b0, m_prod[31:0]});
        do_start();
        #2 reset = 1'b1;
        #1;
        model_clear();
        checkOutput("async_reset_status", state_reg, 32'h1);
        checkOutput("async_reset_out_val", out_val, 32'h0);
        checkOutput("async_reset_core_start", core_start, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        core_product = {8{$urandom | 32'h1}};
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        checkOutput("post_reset_done_ignored", state_reg, model_status());
        read_all("post_reset_product");

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
